float_accumulator: RTL and testbench

//   Downstream consumer of the fixed-to-float converter: sums a stream of

---
 rtl/float_accumulator.sv | 167 ++++++++++++++++
 tb/tb_float_accumulator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/float_accumulator.sv
// Running IEEE-754 single-precision accumulator: multi-cycle align/add/normalize/pack
// adder behind a valid/ready handshake. Rounding is truncation; denormals flush to zero.
module float_accumulator #(
   parameter int MAX_NORM_SHIFTS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_float,
   output logic [31:0] acc_result,
   output logic        result_valid,
   output logic        busy
);

   localparam int CNT_W = $clog2(MAX_NORM_SHIFTS + 1);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_KEEP} special_t;

   state_t             state_reg, state_next;
   special_t           special_reg, special_next;
   logic [31:0]        op_reg, op_next;
   logic [31:0]        acc_reg, acc_next;
   logic               rv_reg, rv_next;
   logic               a_sign_reg, a_sign_next;
   logic signed [9:0]  a_exp_reg, a_exp_next;
   logic [24:0]        a_mant_reg, a_mant_next;
   logic [23:0]        b_mant_reg, b_mant_next;
   logic               sub_reg, sub_next;
   logic [CNT_W-1:0]   norm_cnt_reg, norm_cnt_next;

   // Flushed magnitudes: exponent 0 means the value is treated as exact zero.
   logic [30:0] acc_mag, op_mag, big_mag, small_mag;
   logic        op_larger, big_sign, small_sign;
   logic [23:0] big_mant, small_mant, small_aligned;
   logic [7:0]  exp_diff;
   logic [24:0] sum;

   assign acc_mag       = (acc_reg[30:23] == 8'd0) ? 31'd0 : acc_reg[30:0];
   assign op_mag        = (op_reg[30:23] == 8'd0) ? 31'd0 : op_reg[30:0];
   assign op_larger     = op_mag > acc_mag;
   assign big_mag       = op_larger ? op_mag : acc_mag;
   assign small_mag     = op_larger ? acc_mag : op_mag;
   assign big_sign      = op_larger ? op_reg[31] : acc_reg[31];
   assign small_sign    = op_larger ? acc_reg[31] : op_reg[31];
   assign big_mant      = (big_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, big_mag[22:0]};
   assign small_mant    = (small_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, small_mag[22:0]};
   assign exp_diff      = big_mag[30:23] - small_mag[30:23];
   assign small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_mant >> exp_diff);
   assign sum           = sub_reg ? (a_mant_reg - {1'b0, b_mant_reg})
                                  : (a_mant_reg + {1'b0, b_mant_reg});

   always_comb begin
      state_next    = state_reg;
      special_next  = special_reg;
      op_next       = op_reg;
      acc_next      = acc_reg;
      rv_next       = 1'b0;
      a_sign_next   = a_sign_reg;
      a_exp_next    = a_exp_reg;
      a_mant_next   = a_mant_reg;
      b_mant_next   = b_mant_reg;
      sub_next      = sub_reg;
      norm_cnt_next = norm_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               op_next    = in_float;
               state_next = ALIGN;
            end
         end
         ALIGN: begin
            a_sign_next = big_sign;
            a_exp_next  = {2'b00, big_mag[30:23]};
            a_mant_next = {1'b0, big_mant};
            b_mant_next = small_aligned;
            sub_next    = big_sign ^ small_sign;
            if (op_reg[30:23] == 8'hFF)
               special_next = SP_NAN;
            else if (acc_reg[30:23] == 8'hFF)
               special_next = SP_KEEP;
            else
               special_next = SP_NONE;
            state_next = ADD;
         end
         ADD: begin
            norm_cnt_next = '0;
            if (sum == 25'd0) begin
               a_mant_next = 25'd0;
               a_exp_next  = 10'sd0;
               a_sign_next = 1'b0;
            end else if (sum[24]) begin
               a_mant_next = sum >> 1;
               a_exp_next  = a_exp_reg + 10'sd1;
            end else begin
               a_mant_next = sum;
            end
            state_next = NORM;
         end
         NORM: begin
            if (special_reg != SP_NONE || a_mant_reg[23] || a_mant_reg == 25'd0 ||
                norm_cnt_reg == CNT_W'(MAX_NORM_SHIFTS)) begin
               state_next = PACK;
            end else begin
               a_mant_next   = a_mant_reg << 1;
               a_exp_next    = a_exp_reg - 10'sd1;
               norm_cnt_next = norm_cnt_reg + 1'b1;
            end
         end
         PACK: begin
            if (special_reg == SP_NAN)
               acc_next = 32'h7FC0_0000;
            else if (special_reg == SP_KEEP)
               acc_next = acc_reg;
            else if (a_mant_reg == 25'd0 || a_exp_reg <= 10'sd0)
               acc_next = 32'h0000_0000;
            else if (a_exp_reg >= 10'sd255)
               acc_next = {a_sign_reg, 31'h7F80_0000};
            else
               acc_next = {a_sign_reg, a_exp_reg[7:0], a_mant_reg[22:0]};
            rv_next    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         special_reg  <= SP_NONE;
         op_reg       <= '0;
         acc_reg      <= '0;
         rv_reg       <= 1'b0;
         a_sign_reg   <= 1'b0;
         a_exp_reg    <= '0;
         a_mant_reg   <= '0;
         b_mant_reg   <= '0;
         sub_reg      <= 1'b0;
         norm_cnt_reg <= '0;
      end else if (clear) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         rv_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         special_reg  <= special_next;
         op_reg       <= op_next;
         acc_reg      <= acc_next;
         rv_reg       <= rv_next;
         a_sign_reg   <= a_sign_next;
         a_exp_reg    <= a_exp_next;
         a_mant_reg   <= a_mant_next;
         b_mant_reg   <= b_mant_next;
         sub_reg      <= sub_next;
         norm_cnt_reg <= norm_cnt_next;
      end
   end

   assign acc_result   = acc_reg;
   assign result_valid = rv_reg;
   assign in_ready     = (state_reg == IDLE);
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator: hand-computed sums, latencies, specials,
// clear/reset aborts. One line per transaction.
module tb_float_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_float = '0;
   logic [31:0] acc_result;
   logic        result_valid;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   float_accumulator #(.MAX_NORM_SHIFTS(24)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_float     (in_float),
      .acc_result   (acc_result),
      .result_valid (result_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand, wait for the pulse, check latency/result; hold keeps in_valid up.
   task automatic feed(input logic [31:0] val, input logic [31:0] want,
                       input int want_lat, input bit hold);
      int lat;
      bit seen;
      seen = 1'b0;
      in_valid = 1'b1;
      in_float = val;
      tick();
      if (!hold) in_valid = 1'b0;
      for (lat = 1; lat <= 100; lat++) begin
         tick();
         if (result_valid) begin
            seen = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      check("latency", 32'(lat), 32'(want_lat));
      check("acc", acc_result, want);
      check("ready_in_pulse", {31'd0, in_ready}, 32'd1);
      $display("[TB] add 0x%08h -> acc 0x%08h after %0d cycles (seen=%0d)",
               val, acc_result, lat, seen);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   int pulses;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_acc", acc_result, 32'h0);
      check("rst_rv", {31'd0, result_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);

      // 0 + 1.0 = 1.0, then 1.0 + 2.0 = 3.0 (back-to-back after the pulse)
      feed(32'h3F80_0000, 32'h3F80_0000, 4, 1'b0);
      feed(32'h4000_0000, 32'h4040_0000, 4, 1'b0);
      // 3 + -3 cancels to +0, then + 0.5
      feed(32'hC040_0000, 32'h0000_0000, 4, 1'b0);
      feed(32'h3F00_0000, 32'h3F00_0000, 4, 1'b0);

      // 2^24 + 1 : addend fully shifted out by alignment
      do_clear();
      check("clear_acc", acc_result, 32'h0);
      feed(32'h4B80_0000, 32'h4B80_0000, 4, 1'b0);
      feed(32'h3F80_0000, 32'h4B80_0000, 4, 1'b0);

      // Overflow to +inf, then -inf operand gives NaN, which stays sticky
      do_clear();
      feed(32'h7F7F_FFFF, 32'h7F7F_FFFF, 4, 1'b0);
      feed(32'h7F7F_FFFF, 32'h7F80_0000, 4, 1'b0);
      feed(32'h3F80_0000, 32'h7F80_0000, 4, 1'b0);
      feed(32'hFF80_0000, 32'h7FC0_0000, 4, 1'b0);
      feed(32'h3F80_0000, 32'h7FC0_0000, 4, 1'b0);

      // -2 + 1 = -1 needs one normalize shift; a denormal operand adds nothing
      do_clear();
      feed(32'hC000_0000, 32'hC000_0000, 4, 1'b0);
      feed(32'h3F80_0000, 32'hBF80_0000, 5, 1'b0);
      feed(32'h0000_0001, 32'hBF80_0000, 4, 1'b0);

      // 1.0 - (1 - 2^-24): alignment drops the subtrahend's LSB, so the
      // difference is 2^-23 after 23 shifts. in_valid stays high throughout.
      do_clear();
      feed(32'h3F80_0000, 32'h3F80_0000, 4, 1'b0);
      feed(32'hBF7F_FFFF, 32'h3400_0000, 27, 1'b1);
      tick();
      check("single_accept_busy", {31'd0, busy}, 32'd0);
      check("single_accept_rv", {31'd0, result_valid}, 32'd0);

      // clear while normalizing: op aborted, no pulse
      do_clear();
      feed(32'h3F80_0000, 32'h3F80_0000, 4, 1'b0);
      in_valid = 1'b1;
      in_float = 32'hBF7F_FFFF;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("abort_acc", acc_result, 32'h0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (result_valid) pulses++;
         tick();
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);
      $display("[TB] clear during NORM -> acc 0x%08h, pulses %0d", acc_result, pulses);

      // reset mid-operation behaves like power-on reset
      feed(32'h4000_0000, 32'h4000_0000, 4, 1'b0);
      in_valid = 1'b1;
      in_float = 32'h3F80_0000;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_acc", acc_result, 32'h0);
      check("midrst_rv", {31'd0, result_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ready", {31'd0, in_ready}, 32'd1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (result_valid) pulses++;
         tick();
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      $display("[TB] reset mid-op -> acc 0x%08h, pulses %0d", acc_result, pulses);
      feed(32'h4000_0000, 32'h4000_0000, 4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
